// File: rtl/ram_stream_master.sv
// ram_stream_master
//   Drives a single-port RAM either as a read streamer (words pushed out on a
//   valid/ready stream) or as a block filler (a constant pattern written to a
//   run of consecutive addresses). Addresses wrap modulo 2^ADDR_W.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         request pulse (taken in IDLE only); 0 = read, 1 = fill
//   base, len, fill_val first address, word count (0..2^ADDR_W), fill pattern
//   abort               cancel a running READ or FILL (no done pulse)
//   mem_addr/mem_d/mem_we/mem_q   RAM port, mem_q combinational from mem_addr
//   out_data/out_valid/out_ready  read stream
//   busy, done          operation in progress, one-cycle completion pulse
module ram_stream_master #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   pattern;
  logic                last_word;

  assign last_word = (cnt == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      pattern <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr     <= base;
            cnt     <= len;
            pattern <= fill_val;
            if (len == '0)
              state <= DONE;
            else if (mode)
              state <= FILL;
            else
              state <= READ;
          end
        end
        READ: begin
          // out_valid is always high here, so out_ready alone is the handshake.
          // A handshake coinciding with abort still consumes the word.
          if (out_ready) begin
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt - (ADDR_W+1)'(1);
          end
          if (abort)
            state <= IDLE;
          else if (out_ready && last_word)
            state <= DONE;
        end
        FILL: begin
          // The write of this cycle happens regardless of abort.
          ptr <= ptr + ADDR_W'(1);
          cnt <= cnt - (ADDR_W+1)'(1);
          if (abort)
            state <= IDLE;
          else if (last_word)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are a pure decode of registered state, so reset clears them
  // asynchronously along with the state register.
  always_comb begin
    mem_addr  = ptr;
    mem_d     = '0;
    mem_we    = 1'b0;
    out_data  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      READ: begin
        out_data  = mem_q;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      FILL: begin
        mem_d  = pattern;
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_stream_master.sv
module tb_ram_stream_master;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_val = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  ram_stream_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
    .len(len), .fill_val(fill_val), .abort(abort), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: DUT writes, plus a bench-side preload port.
  logic [DW-1:0] ram [1024];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_d;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_q = ram[mem_addr];

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0, done_cnt = 0, ov_cnt = 0, wr_cnt = 0, b2_cnt = 0;
  logic [DW-1:0]    rd_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic             prev_stall = 1'b0;
  logic [DW-1:0]    prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (!out_valid) check("out_data_zero", {16'h0, out_data}, 32'h0);
      if (!mem_we)    check("mem_d_zero", {16'h0, mem_d}, 32'h0);
      if (out_valid) begin
        ov_cnt++;
        if (out_data == 16'h00B2) b2_cnt++;
        if (prev_stall) check("rd_stable", {16'h0, out_data}, {16'h0, prev_data});
        if (out_ready) begin
          if (rd_q.size() == 0) check("rd_unexpected", 32'h1, 32'h0);
          else check("rd_data", {16'h0, out_data}, {16'h0, rd_q.pop_front()});
        end
      end
      if (mem_we) begin
        wr_cnt++;
        if (wr_q.size() == 0) check("wr_unexpected", 32'h1, 32'h0);
        else check("wr_addr_data", {6'h0, mem_addr, mem_d}, {6'h0, wr_q.pop_front()});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; ov_cnt = 0; wr_cnt = 0; b2_cnt = 0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic do_start(input logic m, input logic [AW-1:0] b, input logic [AW:0] l,
                          input logic [DW-1:0] fv);
    mode = m; base = b; len = l; fill_val = fv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'h0, seen}, 32'h1);
  endtask

  task automatic push_abcd();
    rd_q.push_back(16'h00A1);
    rd_q.push_back(16'h00B2);
    rd_q.push_back(16'h00C3);
    rd_q.push_back(16'h00D4);
  endtask

  task automatic run_read_basic(input logic abort_at_start);
    clear_counts();
    push_abcd();
    abort = abort_at_start;
    do_start(1'b0, 10'd5, 11'd4, 16'h0);
    abort = 1'b0;
    check("rd_first_valid", {31'h0, out_valid}, 32'h1);
    check("rd_first_busy", {31'h0, busy}, 32'h1);
    wait_done(20);
    repeat (2) @(posedge clk);
    #1;
    check("rd_busy_cycles", busy_cnt, 4);
    check("rd_done_cycles", done_cnt, 1);
    check("rd_words", ov_cnt, 4);
    check("rd_q_empty", rd_q.size(), 0);
    check("rd_end_ptr", {22'h0, mem_addr}, 32'd9);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy_done", {30'h0, busy, done}, 32'h0);
    check("rst_data", {mem_d, out_data}, 32'h0);

    poke(10'd5, 16'h00A1);
    poke(10'd6, 16'h00B2);
    poke(10'd7, 16'h00C3);
    poke(10'd8, 16'h00D4);
    poke(10'd2, 16'h1234);
    poke(10'd102, 16'h0000);
    rst_n = 1'b1;

    // Basic read stream
    run_read_basic(1'b0);

    // Backpressure on the second word
    clear_counts();
    push_abcd();
    do_start(1'b0, 10'd5, 11'd4, 16'h0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(20);
    repeat (2) @(posedge clk);
    #1;
    check("bp_b2_cycles", b2_cnt, 4);
    check("bp_busy_cycles", busy_cnt, 7);
    check("bp_done_cycles", done_cnt, 1);
    check("bp_q_empty", rd_q.size(), 0);

    // Fill with address wrap
    clear_counts();
    for (int i = 0; i < 4; i++) wr_q.push_back({AW'(1022 + i), 16'h5A5A});
    do_start(1'b1, 10'd1022, 11'd4, 16'h5A5A);
    check("fill_first_we", {31'h0, mem_we}, 32'h1);
    wait_done(20);
    repeat (2) @(posedge clk);
    #1;
    check("fill_ram1022", {16'h0, ram[1022]}, 32'h5A5A);
    check("fill_ram1023", {16'h0, ram[1023]}, 32'h5A5A);
    check("fill_ram0", {16'h0, ram[0]}, 32'h5A5A);
    check("fill_ram1", {16'h0, ram[1]}, 32'h5A5A);
    check("fill_ram2_kept", {16'h0, ram[2]}, 32'h1234);
    check("fill_writes", wr_cnt, 4);
    check("fill_busy_cycles", busy_cnt, 4);
    check("fill_done_cycles", done_cnt, 1);
    check("fill_q_empty", wr_q.size(), 0);

    // Zero length
    clear_counts();
    do_start(1'b1, 10'd300, 11'd0, 16'hFFFF);
    check("zl_done", {31'h0, done}, 32'h1);
    check("zl_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1 check("zl_done_one_cycle", {31'h0, done}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("zl_writes", wr_cnt, 0);
    check("zl_valids", ov_cnt, 0);
    check("zl_busy_cycles", busy_cnt, 0);
    check("zl_done_cycles", done_cnt, 1);

    // Abort on the second fill cycle
    clear_counts();
    wr_q.push_back({10'd100, 16'hBEEF});
    wr_q.push_back({10'd101, 16'hBEEF});
    do_start(1'b1, 10'd100, 11'd8, 16'hBEEF);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("ab_idle", {31'h0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("ab_writes", wr_cnt, 2);
    check("ab_no_done", done_cnt, 0);
    check("ab_ram101", {16'h0, ram[101]}, 32'hBEEF);
    check("ab_ram102", {16'h0, ram[102]}, 32'h0);
    check("ab_q_empty", wr_q.size(), 0);

    // Reset mid-READ, then a clean read (with abort held while idle)
    clear_counts();
    push_abcd();
    do_start(1'b0, 10'd5, 11'd4, 16'h0);
    @(posedge clk);
    #1;
    #1 rst_n = 1'b0;
    #1;
    check("rr_out_valid", {31'h0, out_valid}, 32'h0);
    check("rr_busy", {31'h0, busy}, 32'h0);
    check("rr_mem_addr", {22'h0, mem_addr}, 32'h0);
    check("rr_out_data", {16'h0, out_data}, 32'h0);
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_read_basic(1'b1);

    // Start ignored while busy and in DONE
    clear_counts();
    push_abcd();
    do_start(1'b0, 10'd5, 11'd4, 16'h0);
    @(posedge clk);
    #1;
    mode = 1'b1; base = 10'd200; len = 11'd1; fill_val = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20);
    mode = 1'b0; base = 10'd300; len = 11'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ig_busy", {31'h0, busy}, 32'h0);
    check("ig_done", {31'h0, done}, 32'h0);
    check("ig_ptr", {22'h0, mem_addr}, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    check("ig_busy_cycles", busy_cnt, 4);
    check("ig_done_cycles", done_cnt, 1);
    check("ig_writes", wr_cnt, 0);
    check("ig_words", ov_cnt, 4);
    check("ig_q_empty", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
